// File: rtl/sc_et_pkg.sv
// Shared definitions for the early-terminating stochastic bitstream counter
// sequencer.
//   state_t      : sequencer states
//   DRAIN_TO_DEF : default number of cycles to wait for the counter's final strobe
//   clamp_len()  : limits a requested stream-length exponent to 1..width-1
package sc_et_pkg;

  typedef enum logic [2:0] {
    IDLE,
    CLEAR,
    RUN,
    DRAIN,
    OUT
  } state_t;

  localparam int unsigned DRAIN_TO_DEF = 16;

  // A zero exponent would give a one-bit stream, which cannot terminate early
  // in any useful way. The upper cap keeps N = 2^len representable in width bits.
  function automatic int unsigned clamp_len(input int unsigned len,
                                            input int unsigned width);
    if (len == 0) return 1;
    if (len > width - 1) return width - 1;
    return len;
  endfunction

endpackage

// File: rtl/et_bound_cmp.sv
// Early-termination bound comparator (purely combinational).
//   bz         : counter value covering 'seen' stream bits
//   seen       : stream bits already reflected in bz
//   n          : total stream length
//   thr        : decision threshold
//   decided_hi : bz has already reached thr, so the decision is "ge"
//   decided_lo : even if every remaining bit were 1, bz cannot reach thr
module et_bound_cmp #(
  parameter int unsigned WIDTH = 8
) (
  input  logic [WIDTH-1:0] bz,
  input  logic [WIDTH-1:0] seen,
  input  logic [WIDTH-1:0] n,
  input  logic [WIDTH-1:0] thr,
  output logic             decided_hi,
  output logic             decided_lo
);

  // Best-case final count; one extra bit so bz + remaining never wraps.
  logic [WIDTH:0] reach;

  always_comb begin
    reach      = {1'b0, bz} + {1'b0, n - seen};
    decided_hi = bz >= thr;
    decided_lo = reach < {1'b0, thr};
  end

endmodule

// File: rtl/ret_sbc_ctrl.sv
// Sequencer for one early-terminating stochastic bitstream counter and its SNG.
// For each request it clears the counter, loads the SNG seed, streams up to
// N = 2^len bits, stops early once the threshold decision can no longer
// change, hands done to the counter, waits for done_p2 and then presents the
// result on a valid/ready port.
//   clk, rst            : clock, asynchronous active-high reset
//   start               : request pulse, accepted in IDLE only
//   len_log2/et_en/thr  : request parameters, captured with start
//   busy                : high in every state except IDLE
//   cnt_clr, sng_load   : one-cycle counter clear / seed load
//   sng_en              : one stream bit per high cycle
//   done / done_p2      : end-of-stream level to counter / counter final strobe
//   bz                  : counter running value
//   res_valid/res_ready : result handshake
//   res_bz, res_ge, res_et, res_cycles, res_err : result fields
module ret_sbc_ctrl
  import sc_et_pkg::*;
#(
  parameter  int unsigned WIDTH    = 8,
  parameter  int unsigned DRAIN_TO = DRAIN_TO_DEF,
  localparam int unsigned LW       = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [LW-1:0]    len_log2,
  input  logic             et_en,
  input  logic [WIDTH-1:0] thr,
  output logic             busy,
  output logic             cnt_clr,
  output logic             sng_load,
  output logic             sng_en,
  output logic             done,
  input  logic             done_p2,
  input  logic [WIDTH-1:0] bz,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [WIDTH-1:0] res_bz,
  output logic             res_ge,
  output logic             res_et,
  output logic [WIDTH-1:0] res_cycles,
  output logic             res_err
);

  localparam int unsigned TW = $clog2(DRAIN_TO + 1);

  state_t           state;
  logic [WIDTH-1:0] n_q;
  logic [WIDTH-1:0] thr_q;
  logic             et_en_q;
  logic [WIDTH-1:0] issued;
  logic [TW-1:0]    timer;
  logic             et_stop_q;

  logic             full;
  logic             stop;
  logic             decided_hi;
  logic             decided_lo;

  // issued is a register bumped on each sng_en edge, so its current value is
  // the one-cycle-delayed bit count, i.e. exactly the bits bz already covers.
  et_bound_cmp #(
    .WIDTH (WIDTH)
  ) u_bound (
    .bz         (bz),
    .seen       (issued),
    .n          (n_q),
    .thr        (thr_q),
    .decided_hi (decided_hi),
    .decided_lo (decided_lo)
  );

  // sng_en must react to the bz of this very cycle, so it is the one output
  // left combinational; everything else is registered in the FSM below.
  always_comb begin
    full   = issued == n_q;
    stop   = full | (et_en_q & (issued != '0) & (decided_hi | decided_lo));
    sng_en = (state == RUN) & ~stop;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      n_q        <= '0;
      thr_q      <= '0;
      et_en_q    <= 1'b0;
      issued     <= '0;
      timer      <= '0;
      et_stop_q  <= 1'b0;
      busy       <= 1'b0;
      cnt_clr    <= 1'b0;
      sng_load   <= 1'b0;
      done       <= 1'b0;
      res_valid  <= 1'b0;
      res_bz     <= '0;
      res_ge     <= 1'b0;
      res_et     <= 1'b0;
      res_cycles <= '0;
      res_err    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            state    <= CLEAR;
            busy     <= 1'b1;
            cnt_clr  <= 1'b1;
            sng_load <= 1'b1;
            n_q      <= WIDTH'(32'd1 << clamp_len(32'(len_log2), WIDTH));
            thr_q    <= thr;
            et_en_q  <= et_en;
          end
        end
        CLEAR: begin
          cnt_clr  <= 1'b0;
          sng_load <= 1'b0;
          issued   <= '0;
          state    <= RUN;
        end
        RUN: begin
          if (stop) begin
            state     <= DRAIN;
            done      <= 1'b1;
            timer     <= '0;
            et_stop_q <= ~full;
          end else begin
            issued <= issued + WIDTH'(1);
          end
        end
        DRAIN: begin
          timer <= timer + TW'(1);
          // done_p2 in the last allowed cycle still counts as a clean finish.
          if (done_p2 || (timer == TW'(DRAIN_TO - 1))) begin
            state      <= OUT;
            done       <= 1'b0;
            res_valid  <= 1'b1;
            res_bz     <= bz;
            res_ge     <= decided_hi;
            res_et     <= et_stop_q;
            res_cycles <= issued;
            res_err    <= ~done_p2;
          end
        end
        OUT: begin
          if (res_ready) begin
            state     <= IDLE;
            res_valid <= 1'b0;
            busy      <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
